// File: rtl/hc85_serial_cascade.sv
// Serial HC85 cascade comparator: one 4-bit slice per clock, LSB nibble first,
// reproducing a chain of NIBBLES combinational HC85 parts with a single compare stage.
module hc85_serial_cascade #(
   parameter int unsigned NIBBLES = 4
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic                 START,
   input  logic [4*NIBBLES-1:0] A,
   input  logic [4*NIBBLES-1:0] B,
   input  logic                 I1,
   input  logic                 I2,
   input  logic                 I3,
   output logic                 BUSY,
   output logic                 DONE,
   output logic                 Q1,
   output logic                 Q2,
   output logic                 Q3
);

   localparam int unsigned W    = 4 * NIBBLES;
   localparam int unsigned IdxW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [IdxW-1:0] LastIdx = IdxW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StRun,
      StFin
   } state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [W-1:0]    a_q, a_d;
   logic [W-1:0]    b_q, b_d;
   logic [2:0]      c_q, c_d;
   logic [2:0]      q_q, q_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic [2:0]      c_step;

   // Equal-slice map of a real HC85, including its non-one-hot codes.
   function automatic logic [2:0] cascade_eq(input logic [2:0] c);
      logic [2:0] r;
      if (c[1]) begin
         r = 3'b010;
      end else begin
         unique case ({c[2], c[0]})
            2'b00:   r = 3'b101;
            2'b01:   r = 3'b001;
            2'b10:   r = 3'b100;
            default: r = 3'b000;
         endcase
      end
      return r;
   endfunction

   // Operands shift right each RUN edge so the active slice is always bits [3:0].
   always_comb begin
      if (a_q[3:0] > b_q[3:0]) begin
         c_step = 3'b100;
      end else if (a_q[3:0] < b_q[3:0]) begin
         c_step = 3'b001;
      end else begin
         c_step = cascade_eq(c_q);
      end
   end

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      c_d     = c_q;
      q_d     = q_q;
      busy_d  = busy_q;
      done_d  = 1'b0;

      unique case (state_q)
         StIdle, StFin: begin
            state_d = StIdle;
            busy_d  = 1'b0;
            if (START) begin
               state_d = StRun;
               busy_d  = 1'b1;
               idx_d   = '0;
               a_d     = A;
               b_d     = B;
               c_d     = {I1, I2, I3};
            end
         end
         StRun: begin
            c_d = c_step;
            a_d = a_q >> 4;
            b_d = b_q >> 4;
            if (idx_q == LastIdx) begin
               state_d = StFin;
               q_d     = c_step;
               done_d  = 1'b1;
               busy_d  = 1'b0;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
         default: begin
            state_d = StIdle;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q <= StIdle;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         c_q     <= 3'b000;
         q_q     <= 3'b000;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         c_q     <= c_d;
         q_q     <= q_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign BUSY = busy_q;
   assign DONE = done_q;
   assign Q1   = q_q[2];
   assign Q2   = q_q[1];
   assign Q3   = q_q[0];

endmodule

// File: tb/tb_hc85_serial_cascade.sv
// Bench for hc85_serial_cascade: fixed vectors, random runs against a word-level model,
// reset abort and back-to-back operation on NIBBLES=4, plus NIBBLES=3 and 1 instances.
module tb_hc85_serial_cascade;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start4, start3, start1;
   logic [15:0] a, b;
   logic [2:0]  i;
   logic        busy4, done4, busy3, done3, busy1, done1;
   logic [2:0]  q4, q3, q1;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   hc85_serial_cascade #(.NIBBLES(4)) u_dut4 (
      .CLK(clk), .RST_N(rst_n), .START(start4), .A(a), .B(b),
      .I1(i[2]), .I2(i[1]), .I3(i[0]), .BUSY(busy4), .DONE(done4),
      .Q1(q4[2]), .Q2(q4[1]), .Q3(q4[0])
   );

   hc85_serial_cascade #(.NIBBLES(3)) u_dut3 (
      .CLK(clk), .RST_N(rst_n), .START(start3), .A(a[11:0]), .B(b[11:0]),
      .I1(i[2]), .I2(i[1]), .I3(i[0]), .BUSY(busy3), .DONE(done3),
      .Q1(q3[2]), .Q2(q3[1]), .Q3(q3[0])
   );

   hc85_serial_cascade #(.NIBBLES(1)) u_dut1 (
      .CLK(clk), .RST_N(rst_n), .START(start1), .A(a[3:0]), .B(b[3:0]),
      .I1(i[2]), .I2(i[1]), .I3(i[0]), .BUSY(busy1), .DONE(done1),
      .Q1(q1[2]), .Q2(q1[1]), .Q3(q1[0])
   );

   typedef struct {
      logic [15:0] a;
      logic [15:0] b;
      logic [2:0]  i;
      int          n;
      logic [2:0]  q;
      string       name;
   } vec_t;

   vec_t vecs[12];

   // Word-level reference: the most significant differing nibble decides; if all
   // nibbles match, the cascade input is either fixed or toggles 000<->101 per slice.
   function automatic logic [2:0] model(input logic [15:0] av, input logic [15:0] bv,
                                        input logic [2:0] iv, input int n);
      for (int k = n - 1; k >= 0; k--) begin
         int an, bn;
         an = int'((av >> (4 * k)) & 16'hF);
         bn = int'((bv >> (4 * k)) & 16'hF);
         if (an > bn) return 3'b100;
         if (an < bn) return 3'b001;
      end
      if (iv[1]) return 3'b010;
      if (iv == 3'b100 || iv == 3'b001) return iv;
      if (n % 2 == 0) return iv;
      return iv ^ 3'b101;
   endfunction

   function automatic logic cur_busy(input int n);
      return (n == 4) ? busy4 : (n == 3) ? busy3 : busy1;
   endfunction

   function automatic logic cur_done(input int n);
      return (n == 4) ? done4 : (n == 3) ? done3 : done1;
   endfunction

   function automatic logic [2:0] cur_q(input int n);
      return (n == 4) ? q4 : (n == 3) ? q3 : q1;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_run(input int n, input logic [15:0] av, input logic [15:0] bv,
                         input logic [2:0] iv, input logic [2:0] qexp, input string name);
      logic [2:0] qprev;
      int         busy_cnt;
      int         done_at;
      logic       held;
      @(negedge clk);
      a = av;
      b = bv;
      i = iv;
      qprev = cur_q(n);
      if (n == 4) start4 = 1'b1;
      else if (n == 3) start3 = 1'b1;
      else start1 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      start3 = 1'b0;
      start1 = 1'b0;
      a = ~av;
      b = bv ^ 16'h5A5A;
      i = ~iv;
      busy_cnt = 0;
      done_at  = 0;
      held     = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         if (cur_done(n)) begin
            done_at = k;
            break;
         end
         if (cur_busy(n)) busy_cnt++;
         if (cur_q(n) !== qprev) held = 1'b0;
         @(negedge clk);
      end
      check({name, "_done_lat"}, done_at, n + 1);
      check({name, "_busy_cnt"}, busy_cnt, n);
      check({name, "_q"}, {29'd0, cur_q(n)}, {29'd0, qexp});
      check({name, "_busy_in_done"}, {31'd0, cur_busy(n)}, 32'd0);
      check({name, "_q_held"}, {31'd0, held}, 32'd1);
      @(negedge clk);
      check({name, "_done_pulse"}, {31'd0, cur_done(n)}, 32'd0);
   endtask

   initial begin
      vec_t        bq[$];
      vec_t        v;
      logic [15:0] ra, rb;
      logic [2:0]  ri;
      int          done_seen, last_done, cyc;

      vecs[0]  = '{16'h1234, 16'h1234, 3'b010, 4, 3'b010, "eq_i010"};
      vecs[1]  = '{16'h8000, 16'h7FFF, 3'b010, 4, 3'b100, "msb_wins"};
      vecs[2]  = '{16'h0005, 16'h0006, 3'b100, 4, 3'b001, "nib_over_casc"};
      vecs[3]  = '{16'hABCD, 16'hABCD, 3'b000, 4, 3'b000, "eq_i000_n4"};
      vecs[4]  = '{16'hABCD, 16'hABCD, 3'b101, 4, 3'b101, "eq_i101_n4"};
      vecs[5]  = '{16'h0ABC, 16'h0ABC, 3'b000, 3, 3'b101, "eq_i000_n3"};
      vecs[6]  = '{16'h0000, 16'h0000, 3'b111, 4, 3'b010, "i111"};
      vecs[7]  = '{16'h0010, 16'h0001, 3'b001, 4, 3'b100, "low_diff"};
      vecs[8]  = '{16'h0007, 16'h0007, 3'b000, 1, 3'b101, "n1_eq"};
      vecs[9]  = '{16'h0003, 16'h0009, 3'b100, 1, 3'b001, "n1_lt"};
      vecs[10] = '{16'h0000, 16'h0000, 3'b001, 4, 3'b001, "i001_hold"};
      vecs[11] = '{16'h0000, 16'h0000, 3'b100, 3, 3'b100, "n3_i100"};

      rst_n  = 1'b0;
      start4 = 1'b0;
      start3 = 1'b0;
      start1 = 1'b0;
      a = '0;
      b = '0;
      i = 3'b000;
      repeat (3) @(negedge clk);
      check("rst_busy", {31'd0, busy4}, 32'd0);
      check("rst_done", {31'd0, done4}, 32'd0);
      check("rst_q", {29'd0, q4}, 32'd0);
      rst_n = 1'b1;

      for (int k = 0; k < 12; k++) begin
         do_run(vecs[k].n, vecs[k].a, vecs[k].b, vecs[k].i, vecs[k].q, vecs[k].name);
      end

      for (int k = 0; k < 25; k++) begin
         ra = 16'($urandom);
         case ($urandom_range(0, 2))
            0:       rb = ra;
            1:       rb = ra ^ (16'h1 << (4 * $urandom_range(0, 3)));
            default: rb = 16'($urandom);
         endcase
         ri = 3'($urandom);
         do_run(4, ra, rb, ri, model(ra, rb, ri, 4), "rand");
      end

      // Abort a run by reset after the second nibble.
      do_run(4, 16'hF000, 16'h0000, 3'b010, 3'b100, "pre_abort");
      @(negedge clk);
      a = 16'h0001;
      b = 16'h0000;
      i = 3'b010;
      start4 = 1'b1;
      @(negedge clk);
      start4 = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      check("abort_busy", {31'd0, busy4}, 32'd0);
      check("abort_done", {31'd0, done4}, 32'd0);
      check("abort_q", {29'd0, q4}, 32'd0);
      done_seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (done4) done_seen++;
      end
      check("abort_no_done", done_seen, 0);
      do_run(4, 16'h1234, 16'h1233, 3'b010, 3'b100, "post_abort");

      // START held high with operands changing every cycle.
      last_done = -1;
      @(negedge clk);
      start4 = 1'b1;
      for (cyc = 0; cyc < 40; cyc++) begin
         if (done4) begin
            if (bq.size() == 0) begin
               check("b2b_unexpected_done", 32'd1, 32'd0);
            end else begin
               v = bq.pop_front();
               check("b2b_q", {29'd0, q4}, {29'd0, model(v.a, v.b, v.i, 4)});
            end
            if (last_done >= 0) check("b2b_period", cyc - last_done, 5);
            last_done = cyc;
         end
         a = 16'($urandom);
         b = ($urandom_range(0, 1) == 0) ? a : 16'($urandom);
         i = 3'($urandom);
         if (!busy4) bq.push_back('{a, b, i, 4, 3'b000, "b2b"});
         @(negedge clk);
      end
      start4 = 1'b0;
      for (int k = 0; k < 20 && bq.size() > 0; k++) begin
         if (done4) begin
            v = bq.pop_front();
            check("b2b_tail_q", {29'd0, q4}, {29'd0, model(v.a, v.b, v.i, 4)});
         end
         @(negedge clk);
      end
      check("b2b_drained", bq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
